// File: rtl/fifol1_rr_arb.sv
// Round-robin enqueue arbiter fused with a depth-1 holding stage tagged by source index.
// Define FIFOL1_RR_ARB_FIXED_PRIO_EN for fixed (lowest-index-wins) priority instead.
module fifol1_rr_arb #(
    parameter int unsigned width = 8,
    parameter int unsigned nreq  = 4,
    parameter int unsigned tagw  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [nreq-1:0]         REQ,
    input  logic [nreq*width-1:0]   REQ_D_IN,
    output logic [nreq-1:0]         GNT,
    output logic [width-1:0]        D_OUT,
    output logic [tagw-1:0]         TAG_OUT,
    output logic                    EMPTY_N,
    input  logic                    DEQ,
    input  logic                    CLR
);

    logic             full_q;
    logic [width-1:0] data_q;
    logic [tagw-1:0]  tag_q;
    logic             found;
    logic [tagw-1:0]  win;
    logic [width-1:0] win_data;
    logic             accept;
    logic             grant;

`ifdef FIFOL1_RR_ARB_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < nreq; i++) begin
            if (!found && REQ[i]) begin
                found = 1'b1;
                win   = tagw'(i);
            end
        end
    end
`else
    logic [tagw-1:0] last_q;
    logic [tagw-1:0] idx;

    // Scan upward from the requester after the last winner, wrapping modulo nreq.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= nreq; k++) begin
            idx = tagw'((32'(last_q) + k) % nreq);
            if (!found && REQ[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_q <= tagw'(nreq - 1);
        end else if (grant) begin
            last_q <= win;
        end
    end
`endif

    // RST gating keeps GNT low while reset is held, independent of the inputs.
    assign accept = RST && !CLR && (!full_q || DEQ);
    assign grant  = accept && found;

    always_comb begin
        GNT = '0;
        if (grant) begin
            GNT[win] = 1'b1;
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < nreq; i++) begin
            if (win == tagw'(i)) begin
                win_data = REQ_D_IN[i*width +: width];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full_q <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
        end else if (CLR) begin
            full_q <= 1'b0;
        end else if (grant) begin
            full_q <= 1'b1;
            data_q <= win_data;
            tag_q  <= win;
        end else if (DEQ) begin
            full_q <= 1'b0;
        end
    end

    assign EMPTY_N = full_q;
    assign D_OUT   = data_q;
    assign TAG_OUT = tag_q;

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RST && DEQ && !full_q) begin
            $display("Warning: fifol1_rr_arb: %m -- Dequeuing from empty fifo");
        end
    end
`endif

endmodule

// File: tb/tb_fifol1_rr_arb.sv
// Randomized and directed bench for fifol1_rr_arb against a behavioural arbiter/buffer model.
// Honours FIFOL1_RR_ARB_FIXED_PRIO_EN in the model when the design is built that way.
module tb_fifol1_rr_arb;

    localparam int W = 8;
    localparam int N = 4;
    localparam int T = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [W-1:0]   d_out;
    logic [T-1:0]   tag_out;
    logic           empty_n;
    logic           deq;
    logic           clr;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: head valid, head data/tag, index of most recent winner.
    int         m_full;
    int         m_last;
    int         m_tag;
    logic [W-1:0] m_data;

    fifol1_rr_arb #(.width(W), .nreq(N), .tagw(T)) dut (
        .CLK     (clk),
        .RST     (rst_n),
        .REQ     (req),
        .REQ_D_IN(din),
        .GNT     (gnt),
        .D_OUT   (d_out),
        .TAG_OUT (tag_out),
        .EMPTY_N (empty_n),
        .DEQ     (deq),
        .CLR     (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int model_winner();
        int i;
        if (!rst_n || clr || (m_full != 0 && !deq)) return -1;
`ifdef FIFOL1_RR_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (req[k]) return k;
`else
        for (int k = 1; k <= N; k++) begin
            i = (m_last + k) % N;
            if (req[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_last = N - 1;
        m_tag  = 0;
        m_data = '0;
    endtask

    // Called just after a negedge: drive, check combinational grant and head, advance one cycle.
    task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic q,
                        input logic c);
        int w;
        logic [N-1:0] exp_gnt;
        req = r; din = d; deq = q; clr = c;
        #1;
        w = model_winner();
        exp_gnt = (w < 0) ? '0 : (N'(1) << w);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("empty_n", 32'(empty_n), 32'(m_full != 0));
        check("d_out", 32'(d_out), 32'(m_data));
        check("tag_out", 32'(tag_out), 32'(m_tag));
        @(posedge clk);
        if (c) begin
            m_full = 0;
        end else if (w >= 0) begin
            m_full = 1;
            m_data = d[w*W +: W];
            m_tag  = w;
            m_last = w;
        end else if (q) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom} & {(N*W){1'b1}};
    endfunction

    initial begin
        rst_n = 1'b0; req = '0; din = '0; deq = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_empty_n", 32'(empty_n), 32'(0));
        rst_n = 1'b1;

        // Rotation with continuous dequeue.
        for (int i = 0; i < 9; i++) step(4'b1111, rnd_data(), m_full != 0, 1'b0);

        // Back-pressure: fill head, then hold requester 2 off until dequeue.
        if (m_full != 0) step(4'b0000, rnd_data(), 1'b1, 1'b0);
        step(4'b0001, rnd_data(), 1'b0, 1'b0);
        step(4'b0100, rnd_data(), 1'b0, 1'b0);
        step(4'b0100, rnd_data(), 1'b0, 1'b0);
        step(4'b0100, 32'hA5C3_7E19, 1'b1, 1'b0);
        check("bp_tag2", 32'(tag_out), 32'(2));

        // Skip and wrap: last is 2, only requester 1 asks.
        step(4'b0010, rnd_data(), 1'b1, 1'b0);
        check("wrap_tag1", 32'(tag_out), 32'(1));

        // Flush overrides dequeue and grant.
        step(4'b0001, rnd_data(), 1'b1, 1'b1);
        check("flush_empty", 32'(empty_n), 32'(0));
        step(4'b0001, rnd_data(), 1'b0, 1'b0);
        check("post_flush_tag0", 32'(tag_out), 32'(0));

        // Asynchronous reset mid-cycle with the head full.
        step(4'b1000, rnd_data(), 1'b0, 1'b0);
        req = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_empty_n", 32'(empty_n), 32'(0));
        check("arst_gnt", 32'(gnt), 32'(0));
        check("arst_d_out", 32'(d_out), 32'(0));
        check("arst_tag_out", 32'(tag_out), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, rnd_data(), 1'b0, 1'b0);
        check("arst_first_tag0", 32'(tag_out), 32'(0));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom_range(0, 15)), rnd_data(),
                 (m_full != 0) && ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
